// File: rtl/sync_event_tracker.sv
// sync_event_tracker: qualifies changes on a synchronized bus while the
// upstream stable flag is high. Accepted changes produce one-cycle rise/fall
// pulses, update sticky flags and a saturating event counter, then open a
// holdoff window during which the bus is ignored.
//
// Handshake: there is no valid/ready pair. din_stable acts as a qualifier, so
// din_sync is only sampled on cycles where din_stable=1. clear is a
// single-cycle request that takes effect on the next edge.
module sync_event_tracker #(
  parameter int WIDTH       = 1,
  parameter int HOLDOFF     = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       din_sync,
  input  logic                   din_stable,
  input  logic                   clear,
  output logic [WIDTH-1:0]       level,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall,
  output logic [WIDTH-1:0]       sticky_rise,
  output logic [WIDTH-1:0]       sticky_fall,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic                   armed,
  output logic                   busy
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic [WIDTH-1:0]       level_q, level_d;
  logic [WIDTH-1:0]       rise_q, rise_d;
  logic [WIDTH-1:0]       fall_q, fall_d;
  logic [WIDTH-1:0]       srise_q, srise_d;
  logic [WIDTH-1:0]       sfall_q, sfall_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   armed_q, armed_d;
  logic                   busy_q, busy_d;
  logic                   accept;

  assign accept = din_stable && (din_sync != level_q);

  // Next-state logic: clear is applied first so a coincident event lands on
  // the freshly cleared count and sticky flags.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    srise_d = srise_q;
    sfall_d = sfall_q;
    count_d = count_q;

    if (clear) begin
      count_d = '0;
      srise_d = '0;
      sfall_d = '0;
    end

    case (state_q)
      ST_INIT: begin
        // Initial capture: adopt the bus value silently.
        if (din_stable) begin
          level_d = din_sync;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (accept) begin
          level_d = din_sync;
          rise_d  = din_sync & ~level_q;
          fall_d  = ~din_sync & level_q;
          srise_d = srise_d | rise_d;
          sfall_d = sfall_d | fall_d;
          if (count_d != COUNT_MAX) count_d = count_d + 1'b1;
          if (HOLDOFF > 0) begin
            state_d = ST_HOLDOFF;
            hcnt_d  = HOLD_INIT;
          end
        end
      end
      ST_HOLDOFF: begin
        // Bus ignored; the last holdoff cycle is the one with hcnt_q==0.
        if (hcnt_q == '0) state_d = ST_ARMED;
        else              hcnt_d  = hcnt_q - HW'(1);
      end
      default: state_d = ST_INIT;
    endcase

    armed_d = (state_d == ST_ARMED);
    busy_d  = (state_d == ST_HOLDOFF);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_INIT;
      hcnt_q  <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      srise_q <= '0;
      sfall_q <= '0;
      count_q <= '0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      srise_q <= srise_d;
      sfall_q <= sfall_d;
      count_q <= count_d;
      armed_q <= armed_d;
      busy_q  <= busy_d;
    end
  end

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign sticky_rise = srise_q;
  assign sticky_fall = sfall_q;
  assign event_count = count_q;
  assign armed       = armed_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sync_event_tracker.sv
// Bench for sync_event_tracker: two instances share one 4-bit input bus,
// one with HOLDOFF=4 / 16-bit count, one with HOLDOFF=0 / 2-bit count.
// The reference model tracks the cycle of the last accepted change and
// allows a new one only once HOLDOFF whole cycles have passed.
module tb_sync_event_tracker;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn = 1'b0;
  logic [3:0] din    = '0;
  logic       stable = 1'b0;
  logic       clear  = 1'b0;

  logic [3:0]  a_level, a_rise, a_fall, a_srise, a_sfall;
  logic [15:0] a_count;
  logic        a_armed, a_busy;
  logic [3:0]  b_level, b_rise, b_fall, b_srise, b_sfall;
  logic [1:0]  b_count;
  logic        b_armed, b_busy;

  sync_event_tracker #(.WIDTH(4), .HOLDOFF(4), .COUNT_WIDTH(16)) dut_a (
    .clk(clk), .resetn(resetn), .din_sync(din), .din_stable(stable), .clear(clear),
    .level(a_level), .rise(a_rise), .fall(a_fall), .sticky_rise(a_srise),
    .sticky_fall(a_sfall), .event_count(a_count), .armed(a_armed), .busy(a_busy)
  );

  sync_event_tracker #(.WIDTH(4), .HOLDOFF(0), .COUNT_WIDTH(2)) dut_b (
    .clk(clk), .resetn(resetn), .din_sync(din), .din_stable(stable), .clear(clear),
    .level(b_level), .rise(b_rise), .fall(b_fall), .sticky_rise(b_srise),
    .sticky_fall(b_sfall), .event_count(b_count), .armed(b_armed), .busy(b_busy)
  );

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int         m_hold[2] = '{4, 0};
  int         m_max[2]  = '{65535, 3};
  logic [3:0] m_level[2], m_rise[2], m_fall[2], m_srise[2], m_sfall[2];
  int         m_count[2];
  int         m_last[2];
  bit         m_inited[2];
  bit         m_busy[2], m_armed[2];
  int         cyc = 0;

  int passes = 0;
  int total  = 0;

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // Behavioural model: one input cycle c for configuration m
  task automatic model_step(input int m, input logic rn, input logic [3:0] d,
                            input logic s, input logic c_clr, input int c);
    m_rise[m] = '0;
    m_fall[m] = '0;
    if (!rn) begin
      m_level[m] = '0; m_srise[m] = '0; m_sfall[m] = '0;
      m_count[m] = 0; m_inited[m] = 0; m_last[m] = -100;
    end else begin
      if (c_clr) begin
        m_count[m] = 0; m_srise[m] = '0; m_sfall[m] = '0;
      end
      if (!m_inited[m]) begin
        if (s) begin
          m_level[m]  = d;
          m_inited[m] = 1;
        end
      end else if (s && d != m_level[m] && c >= m_last[m] + m_hold[m] + 1) begin
        m_rise[m]  = d & ~m_level[m];
        m_fall[m]  = ~d & m_level[m];
        m_srise[m] = m_srise[m] | m_rise[m];
        m_sfall[m] = m_sfall[m] | m_fall[m];
        m_level[m] = d;
        if (m_count[m] < m_max[m]) m_count[m] = m_count[m] + 1;
        m_last[m] = c;
      end
    end
    m_busy[m]  = m_inited[m] && (c + 1 <= m_last[m] + m_hold[m]);
    m_armed[m] = m_inited[m] && !m_busy[m];
  endtask

  // Driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic step(input logic rn, input logic [3:0] d, input logic s, input logic c_clr);
    @(negedge clk);
    resetn = rn; din = d; stable = s; clear = c_clr;
    model_step(0, rn, d, s, c_clr, cyc);
    model_step(1, rn, d, s, c_clr, cyc);
    @(posedge clk);
    #1;
    check("a_level", 32'(a_level), 32'(m_level[0]));
    check("a_rise",  32'(a_rise),  32'(m_rise[0]));
    check("a_fall",  32'(a_fall),  32'(m_fall[0]));
    check("a_srise", 32'(a_srise), 32'(m_srise[0]));
    check("a_sfall", 32'(a_sfall), 32'(m_sfall[0]));
    check("a_count", 32'(a_count), 32'(m_count[0]));
    check("a_armed", 32'(a_armed), 32'(m_armed[0]));
    check("a_busy",  32'(a_busy),  32'(m_busy[0]));
    check("b_level", 32'(b_level), 32'(m_level[1]));
    check("b_rise",  32'(b_rise),  32'(m_rise[1]));
    check("b_fall",  32'(b_fall),  32'(m_fall[1]));
    check("b_srise", 32'(b_srise), 32'(m_srise[1]));
    check("b_sfall", 32'(b_sfall), 32'(m_sfall[1]));
    check("b_count", 32'(b_count), 32'(m_count[1]));
    check("b_armed", 32'(b_armed), 32'(m_armed[1]));
    check("b_busy",  32'(b_busy),  32'(m_busy[1]));
    cyc++;
  endtask

  initial begin
    logic [3:0] rd;
    // Reset: all outputs zero
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 1, 0);
    // INIT -> ARMED, silent capture of 0
    step(1, 4'h0, 1, 0);
    // 0->1 accepted, then toggles inside holdoff, din=0 at exit -> fall
    step(1, 4'h1, 1, 0);
    step(1, 4'h0, 1, 0);
    step(1, 4'h1, 1, 0);
    step(1, 4'h0, 1, 0);
    step(1, 4'h0, 1, 0);
    step(1, 4'h0, 1, 0);
    step(1, 4'h0, 1, 0);
    // Change while unstable is held off until stable returns; multi-bit event
    step(1, 4'h5, 0, 0);
    step(1, 4'h5, 0, 0);
    step(1, 4'h5, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 4'h5, 1, 0);
    // Many events to saturate the 2-bit counter
    for (int i = 0; i < 12; i++) step(1, (i % 2 == 0) ? 4'hA : 4'h3, 1, 0);
    // Clear coincident with an accepted change
    for (int i = 0; i < 5; i++) step(1, 4'h3, 1, 0);
    step(1, 4'hC, 1, 1);
    step(1, 4'hC, 1, 0);
    // Reset during holdoff, then silent recapture
    for (int i = 0; i < 5; i++) step(1, 4'hC, 1, 0);
    step(1, 4'h6, 1, 0);
    step(1, 4'h6, 1, 0);
    step(0, 4'h6, 1, 0);
    step(1, 4'h9, 1, 0);
    step(1, 4'h9, 1, 0);
    // Randomized phase
    rd = 4'h9;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) rd = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 59) != 0), rd, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0));
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
